// File: rtl/poly_tone_organ.sv
// poly_tone_organ: NUM_CH square-wave voices with edge-aligned retune, a level mix and a 1-bit audio pin.
// Optional macro POLY_TONE_ORGAN_PWM_EN turns audio_output into a PWM of the mix level.
module poly_tone_organ #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned INFO_CH = 0
) (
    input  logic                          CLK_50M,
    input  logic                          RESET_N,
    input  logic [NUM_CH-1:0]             ch_en,
    input  logic [3*NUM_CH-1:0]           note_sel,
    input  logic [2*NUM_CH-1:0]           octave,
    output logic [NUM_CH-1:0]             ch_wave,
    output logic [$clog2(NUM_CH+1)-1:0]   mix_level,
    output logic                          audio_output,
    output logic [31:0]                   info
);
    localparam int unsigned PW         = 32;
    localparam int unsigned MIX_W      = $clog2(NUM_CH + 1);
    localparam int unsigned INFO_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } voice_state_e;

    // Half-period in clock cycles for each note code: floor(CLK_HZ / (2*f)).
    function automatic logic [PW-1:0] hp_of(input logic [2:0] code);
        case (code)
            3'd0:    hp_of = PW'(CLK_HZ / 1046);
            3'd1:    hp_of = PW'(CLK_HZ / 1174);
            3'd2:    hp_of = PW'(CLK_HZ / 1318);
            3'd3:    hp_of = PW'(CLK_HZ / 1396);
            3'd4:    hp_of = PW'(CLK_HZ / 1566);
            3'd5:    hp_of = PW'(CLK_HZ / 1760);
            3'd6:    hp_of = PW'(CLK_HZ / 1974);
            default: hp_of = PW'(CLK_HZ / 2092);
        endcase
    endfunction

    logic [NUM_CH-1:0][PW-1:0] per_all_c;
    logic [MIX_W-1:0]          pop_c;
    logic [MIX_W-1:0]          mix_level_q;
    logic                      audio_q;
`ifndef POLY_TONE_ORGAN_PWM_EN
    logic [NUM_CH-1:0]         run_c;
    logic                      low_wave_c;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_voice
        voice_state_e  state_q;
        logic [PW-1:0] per_q;
        logic [PW-1:0] cnt_q;
        logic          wave_q;
        logic [PW-1:0] hp_c;
        logic [PW-1:0] per_new_c;

        assign hp_c      = hp_of(note_sel[3*i +: 3]) >> octave[2*i +: 2];
        // A zero period would never match the wrap compare; floor it at one cycle.
        assign per_new_c = (hp_c == '0) ? PW'(1) : hp_c;

        // Voice FSM: the period only reloads at a toggle, so a half-period never shortens mid-flight.
        always_ff @(posedge CLK_50M or negedge RESET_N) begin
            if (!RESET_N) begin
                state_q <= S_IDLE;
                per_q   <= '0;
                cnt_q   <= '0;
                wave_q  <= 1'b0;
            end else if (state_q == S_IDLE) begin
                cnt_q  <= '0;
                wave_q <= 1'b0;
                if (ch_en[i]) begin
                    per_q   <= per_new_c;
                    state_q <= S_RUN;
                end else begin
                    per_q <= '0;
                end
            end else begin
                if (!ch_en[i]) begin
                    state_q <= S_IDLE;
                    per_q   <= '0;
                    cnt_q   <= '0;
                    wave_q  <= 1'b0;
                end else if (cnt_q == per_q - PW'(1)) begin
                    cnt_q  <= '0;
                    wave_q <= ~wave_q;
                    per_q  <= per_new_c;
                end else begin
                    cnt_q <= cnt_q + PW'(1);
                end
            end
        end

        assign ch_wave[i]   = wave_q;
        assign per_all_c[i] = per_q;
`ifndef POLY_TONE_ORGAN_PWM_EN
        assign run_c[i]     = (state_q == S_RUN);
`endif
    end

    always_comb begin
        pop_c = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            pop_c = pop_c + MIX_W'(ch_wave[k]);
        end
    end

    always_ff @(posedge CLK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            mix_level_q <= '0;
        end else begin
            mix_level_q <= pop_c;
        end
    end

`ifdef POLY_TONE_ORGAN_PWM_EN
    localparam int unsigned PWM_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PWM_W-1:0] pwm_cnt_q;

    // Frame counter 0..NUM_CH-1; audio is high for mix_level slots of each frame.
    always_ff @(posedge CLK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            pwm_cnt_q <= '0;
            audio_q   <= 1'b0;
        end else begin
            pwm_cnt_q <= (pwm_cnt_q == PWM_W'(NUM_CH - 1)) ? '0 : pwm_cnt_q + PWM_W'(1);
            audio_q   <= (MIX_W'(pwm_cnt_q) < mix_level_q);
        end
    end
`else
    // Follow the lowest-indexed running voice; silent when nothing runs.
    always_comb begin
        low_wave_c = 1'b0;
        for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
            if (run_c[k]) begin
                low_wave_c = ch_wave[k];
            end
        end
    end

    always_ff @(posedge CLK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            audio_q <= 1'b0;
        end else begin
            audio_q <= low_wave_c;
        end
    end
`endif

    assign mix_level    = mix_level_q;
    assign audio_output = audio_q;
    assign info         = per_all_c[INFO_IDX_W'(INFO_CH)];

endmodule

// File: tb/tb_poly_tone_organ.sv
// Bench for poly_tone_organ: per-cycle compare against a behavioural voice model on a 1 MHz-table
// instance, plus directed note-table and first-edge timing checks on a 50 MHz-table instance.
`timescale 1ns/1ps
module tb_poly_tone_organ;
    localparam int unsigned NCH  = 4;
    localparam int unsigned SCLK = 1_000_000;
    localparam int unsigned MW   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // small-table instance (model-checked)
    logic              rst_n = 1'b1;
    logic [NCH-1:0]    en    = '0;
    logic [3*NCH-1:0]  note  = '0;
    logic [2*NCH-1:0]  oct   = '0;
    logic [NCH-1:0]    wave;
    logic [MW-1:0]     mix;
    logic              aud;
    logic [31:0]       info_s;

    // 50 MHz-table instance
    logic              rst_b_n = 1'b1;
    logic [NCH-1:0]    en_b    = '0;
    logic [3*NCH-1:0]  note_b  = '0;
    logic [2*NCH-1:0]  oct_b   = '0;
    logic [NCH-1:0]    wave_b;
    logic [MW-1:0]     mix_b;
    logic              aud_b;
    logic [31:0]       info_b;

    poly_tone_organ #(.CLK_HZ(SCLK), .NUM_CH(NCH), .INFO_CH(0)) u_dut (
        .CLK_50M(clk), .RESET_N(rst_n), .ch_en(en), .note_sel(note), .octave(oct),
        .ch_wave(wave), .mix_level(mix), .audio_output(aud), .info(info_s)
    );

    poly_tone_organ #(.CLK_HZ(50_000_000), .NUM_CH(NCH), .INFO_CH(0)) u_dut_big (
        .CLK_50M(clk), .RESET_N(rst_b_n), .ch_en(en_b), .note_sel(note_b), .octave(oct_b),
        .ch_wave(wave_b), .mix_level(mix_b), .audio_output(aud_b), .info(info_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned hp_model(input int unsigned clk_hz, input int unsigned code,
                                             input int unsigned sh);
        int unsigned f;
        int unsigned hp;
        case (code)
            0:       f = 523;
            1:       f = 587;
            2:       f = 659;
            3:       f = 698;
            4:       f = 783;
            5:       f = 880;
            6:       f = 987;
            default: f = 1046;
        endcase
        hp = (clk_hz / (2 * f)) >> sh;
        return (hp == 0) ? 1 : hp;
    endfunction

    // Behavioural model: each running voice counts down its half-period and flips at zero.
    bit [NCH-1:0] m_run  = '0;
    bit [NCH-1:0] m_wave = '0;
    int unsigned  m_left [NCH];
    int unsigned  m_per  [NCH];
    int unsigned  m_mix  = 0;
    bit           m_aud  = 1'b0;
    int unsigned  m_pwm  = 0;

    always @(posedge clk or negedge rst_n) begin : model
        bit [NCH-1:0] r;
        bit [NCH-1:0] w;
        int unsigned  lft [NCH];
        int unsigned  per [NCH];
        int unsigned  pop;
        bit           low;
        bit           found;
        if (!rst_n) begin
            m_run  <= '0;
            m_wave <= '0;
            m_mix  <= 0;
            m_aud  <= 1'b0;
            m_pwm  <= 0;
            for (int k = 0; k < NCH; k++) begin
                m_left[k] <= 0;
                m_per[k]  <= 0;
            end
        end else begin
            r = m_run; w = m_wave; lft = m_left; per = m_per;
            pop = 0; low = 1'b0; found = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                pop += w[k];
                if (!found && r[k]) begin
                    low   = w[k];
                    found = 1'b1;
                end
            end
`ifdef POLY_TONE_ORGAN_PWM_EN
            m_aud <= (m_pwm < m_mix);
            m_pwm <= (m_pwm + 1) % NCH;
`else
            m_aud <= low;
`endif
            m_mix <= pop;
            for (int k = 0; k < NCH; k++) begin
                if (!r[k]) begin
                    w[k] = 1'b0;
                    if (en[k]) begin
                        r[k]   = 1'b1;
                        per[k] = hp_model(SCLK, note[3*k +: 3], oct[2*k +: 2]);
                        lft[k] = per[k];
                    end else begin
                        per[k] = 0;
                    end
                end else if (!en[k]) begin
                    r[k] = 1'b0; w[k] = 1'b0; per[k] = 0;
                end else begin
                    lft[k]--;
                    if (lft[k] == 0) begin
                        w[k]   = ~w[k];
                        per[k] = hp_model(SCLK, note[3*k +: 3], oct[2*k +: 2]);
                        lft[k] = per[k];
                    end
                end
            end
            m_run  <= r;
            m_wave <= w;
            m_left <= lft;
            m_per  <= per;
        end
    end

    always @(negedge clk) begin
        check("cyc_wave", 32'(wave), 32'(m_wave));
        check("cyc_mix", 32'(mix), m_mix);
        check("cyc_audio", 32'(aud), 32'(m_aud));
        check("cyc_info", info_s, m_per[0]);
    end

    task automatic wait_wave(input bit big, input int k, input bit val, input int budget,
                             output int unsigned t);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            seen = big ? (wave_b[k] == val) : (wave[k] == val);
        end
        t = cyc;
        check("wave_edge_seen", 32'(seen), 32'd1);
    endtask

    task automatic run_small();
        int unsigned t0, t1, t2;
        int unsigned highs;
        repeat (3) @(negedge clk);
        check("rst_wave", 32'(wave), 0);
        check("rst_info", info_s, 0);
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        check("idle_wave", 32'(wave), 0);
        check("idle_mix", 32'(mix), 0);
        check("idle_audio", 32'(aud), 0);
        check("idle_info", info_s, 0);

        // voice 0, note 0, octave 0
        en[0] = 1'b1;
        @(posedge clk); #1 t0 = cyc;
        check("v0_info", info_s, 956);
        wait_wave(0, 0, 1'b1, 2000, t1); check("v0_first_rise", t1 - t0, 956);
        wait_wave(0, 0, 1'b0, 2000, t2); check("v0_half_a", t2 - t1, 956);
        wait_wave(0, 0, 1'b1, 2000, t1); check("v0_half_b", t1 - t2, 956);
        en[0] = 1'b0;
        @(negedge clk);
        check("v0_off_wave", 32'(wave[0]), 0);
        check("v0_off_info", info_s, 0);

        // voice 1 retuned mid half-period
        note[5:3] = 3'd7; oct[3:2] = 2'd2; en[1] = 1'b1;
        @(posedge clk); #1 t0 = cyc;
        wait_wave(0, 1, 1'b1, 500, t1); check("v1_first_rise", t1 - t0, 119);
        repeat (50) @(negedge clk);
        note[5:3] = 3'd5;
        wait_wave(0, 1, 1'b0, 500, t2); check("v1_old_half", t2 - t1, 119);
        wait_wave(0, 1, 1'b1, 500, t1); check("v1_new_half", t1 - t2, 142);
        wait_wave(0, 1, 1'b0, 500, t2); check("v1_new_half2", t2 - t1, 142);
        en[1] = 1'b0;

        // voice 2 disabled on the edge where it would rise
        note[8:6] = 3'd3; oct[5:4] = 2'd3; en[2] = 1'b1;
        @(posedge clk); #1 t0 = cyc;
        wait_wave(0, 2, 1'b1, 500, t1); check("v2_first_rise", t1 - t0, 89);
        wait_wave(0, 2, 1'b0, 500, t2); check("v2_half", t2 - t1, 89);
        repeat (88) @(negedge clk);
        check("v2_low_before", 32'(wave[2]), 0);
        en[2] = 1'b0;
        @(negedge clk); check("v2_off_at_toggle", 32'(wave[2]), 0);
        repeat (2) @(negedge clk); check("v2_stays_idle", 32'(wave[2]), 0);

        // voice 3 retuned on the toggle edge itself
        note[11:9] = 3'd1; oct[7:6] = 2'd3; en[3] = 1'b1;
        @(posedge clk); #1 t0 = cyc;
        wait_wave(0, 3, 1'b1, 500, t1); check("v3_first_rise", t1 - t0, 106);
        repeat (105) @(negedge clk);
        note[11:9] = 3'd6;
        wait_wave(0, 3, 1'b0, 500, t2); check("v3_old_half", t2 - t1, 106);
        wait_wave(0, 3, 1'b1, 500, t1); check("v3_new_half", t1 - t2, 63);
        en = '0;
        repeat (3) @(negedge clk);

        // all four voices together
        note = '0; oct = '0; en = 4'hf;
        @(posedge clk); #1 t0 = cyc;
        wait_wave(0, 0, 1'b1, 2000, t1); check("all_first_rise", t1 - t0, 956);
        check("all_rise_together", 32'(wave), 32'hf);
        check("mix_lag", 32'(mix), 0);
        @(negedge clk);
        check("mix_four", 32'(mix), 4);
`ifdef POLY_TONE_ORGAN_PWM_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); check("pwm_full_frame", 32'(aud), 1);
        end
        en = 4'b0001;
        repeat (4) @(negedge clk);
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); highs += aud;
        end
        check("pwm_quarter_duty", highs, 2);
`else
        highs = 0;
        check("aud_lowest", 32'(aud), 1);
`endif

        // asynchronous reset with three voices running
        note[5:3] = 3'd7; oct[3:2] = 2'd2; en = 4'b0111;
        repeat (200) @(negedge clk);
        check("pre_reset_wave0", 32'(wave[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_wave", 32'(wave), 0);
        check("async_mix", 32'(mix), 0);
        check("async_audio", 32'(aud), 0);
        check("async_info", info_s, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1 t0 = cyc;
        check("post_rst_info", info_s, 956);
        wait_wave(0, 1, 1'b1, 500, t1); check("post_rst_v1_rise", t1 - t0, 119);
        wait_wave(0, 0, 1'b1, 2000, t2); check("post_rst_v0_rise", t2 - t0, 956);
        en = '0;
        repeat (5) @(negedge clk);
    endtask

    task automatic run_big();
        int unsigned exp50 [8];
        int unsigned t0, t1;
        exp50 = '{47801, 42589, 37936, 35816, 31928, 28409, 25329, 23900};
        repeat (3) @(negedge clk);
        rst_b_n = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            note_b[2:0] = 3'(c); oct_b[1:0] = 2'd0; en_b[0] = 1'b1;
            @(negedge clk); check("big_note_info", info_b, exp50[c]);
            en_b[0] = 1'b0;
            @(negedge clk); check("big_info_clear", info_b, 0);
        end
        note_b[2:0] = 3'd7; oct_b[1:0] = 2'd2; en_b[0] = 1'b1;
        @(negedge clk); check("big_n7_o2", info_b, 5975);
        en_b[0] = 1'b0; @(negedge clk);
        note_b[2:0] = 3'd5; en_b[0] = 1'b1;
        @(negedge clk); check("big_n5_o2", info_b, 7102);
        en_b[0] = 1'b0; @(negedge clk);
        note_b[2:0] = 3'd0; oct_b[1:0] = 2'd0; en_b[0] = 1'b1;
        @(posedge clk); #1 t0 = cyc;
        wait_wave(1, 0, 1'b1, 50000, t1);
        check("big_first_rise", t1 - t0, 47801);
        check("big_info_run", info_b, 47801);
        en_b[0] = 1'b0;
        @(negedge clk); check("big_off_wave", 32'(wave_b), 0);
    endtask

    initial begin
        #1;
        rst_n   = 1'b0;
        rst_b_n = 1'b0;
        fork
            run_small();
            run_big();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/poly_tone_organ.md
# poly_tone_organ

Parametrised multi-channel successor to the single-voice switch-driven tone organ. NUM_CH independent square-wave voices each select one of eight notes plus an octave shift. Voices retune glitch-free at waveform edges, and their levels are summed into a mix level. The mix drives a 1-bit audio pin and a 32-bit info/debug word, and the block sits between the board switches/keys and the audio output pin.

## Interface
Parameters:
- CLK_HZ, 50_000_000: input clock frequency; sets the note table.
- NUM_CH, 4: voice count, 1..8.
- INFO_CH, 0: voice whose latched half-period is reported on info.

Ports:
- CLK_50M  in  1  sole clock.
- RESET_N  in  1  asynchronous, active-low reset.
- ch_en  in  NUM_CH  per-voice enable. Bit i enables voice i.
- note_sel  in  3*NUM_CH  per-voice note code. Bits [3i+2:3i] belong to voice i.
- octave  in  2*NUM_CH  per-voice octave shift 0..3, upward.
- ch_wave  out  NUM_CH  per-voice square wave, registered.
- mix_level  out  $clog2(NUM_CH+1)  count of voices whose ch_wave is high.
- audio_output  out  1  audio pin.
- info  out  32  latched half-period of voice INFO_CH.

## Operation
- Note table: half-period count HP = floor(CLK_HZ / (2*f)).
  - f for codes 0..7 = 523, 587, 659, 698, 783, 880, 987, 1046 Hz.
  - At 50 MHz, HP = 47801, 42589, 37936, 35816, 31928, 28409, 25329, 23900.
- Effective period: HP >> octave, computed in 32 bits.
- Per-voice state machine, states IDLE and RUN:
  - IDLE:
    - cnt = 0 and ch_wave = 0.
    - When ch_en is high: latch period P = HP(note_sel) >> octave, then go to RUN.
  - RUN:
    - cnt increments each cycle.
    - When cnt == P-1: cnt <= 0, ch_wave toggles, and P re-latches from the current note_sel/octave.
  - RUN with ch_en low: go to IDLE next cycle. ch_wave <= 0 and cnt <= 0 immediately, with no wait for an edge.
- Retune rule:
  - note_sel/octave changes while in RUN take effect only at the next toggle.
  - The current half-period always completes at its old length, so there are no runt pulses.
- Mix:
  - mix_level = popcount(ch_wave), registered.
  - mix_level lags ch_wave by 1 cycle.
- info = zero-extended P of voice INFO_CH. It reads 0 while that voice is IDLE, and P clears on entry to IDLE.

## Timing
- Reset (asynchronous assert, synchronous release): all counters, P, ch_wave, mix_level, audio_output, info = 0, and every voice is in IDLE.
- ch_en rising at cycle 0:
  - P is latched at the cycle-0 edge.
  - The first ch_wave rise occurs P cycles later.
  - Thereafter ch_wave toggles every P cycles, giving period 2P.
- ch_en falling: ch_wave = 0 one cycle after the sampling edge.
- The ch_en fall and a toggle in the same cycle resolve to IDLE (ch_wave = 0).
- A note change and a toggle in the same cycle: the new P applies to the half-period that starts at that toggle.
- Reset mid-note: output goes low immediately. After release, voices re-enter RUN from IDLE per the enable rule.
- Counter wrap is exact: there are no off-by-one extra cycles.

## Configuration
- Macro: POLY_TONE_ORGAN_PWM_EN.
- Defined:
  - A free-running pwm_cnt counts 0..NUM_CH-1 and wraps.
  - audio_output (registered) = (pwm_cnt < mix_level).
  - Duty cycle over each NUM_CH-cycle frame = mix_level / NUM_CH.
- Undefined:
  - audio_output = ch_wave of the lowest-indexed voice in RUN, delayed 1 register stage.
  - audio_output = 0 if no voice is in RUN.
  - No pwm_cnt exists.

## Test plan
- Reset with all inputs 0: every output is 0, and holds for 1000 cycles.
- Voice 0: note 0, octave 0, ch_en[0] 0→1.
  - First ch_wave[0] rise 47801 cycles after the enable edge.
  - Toggles every 47801 cycles thereafter.
  - info = 47801.
- Voice 1: note 7, octave 2.
  - Half-period = 5975.
  - Change to note 5 mid half-period: the current half-period completes at 5975, then subsequent half-periods are 7102.
- Voices 0..3 enabled, all note 0, octave 0, enabled on the same edge.
  - All four voices rise together; mix_level = 4 one cycle later.
  - With the macro defined: audio_output stays high for a full 4-cycle frame.
- Voice 0 running at mix_level 1 with the macro defined: audio_output pattern is 1,0,0,0 per frame. Deassert ch_en[0]: ch_wave[0] = 0 next cycle, and info = 0.
- Assert RESET_N low mid-half-period with 3 voices running.
  - All outputs are 0 asynchronously.
  - After release with ch_en still high, each voice restarts and its first rise comes exactly P cycles after the first post-reset edge.
